mem_stage_dmem: RTL and testbench
=================================

// Module: mem_stage_dmem
// PURPOSE
//  Data-memory responder for the MEM stage of the 5-stage RISC-V pipeline. It sits downstream of the EX/MEM register.
//  It consumes MemRead/MemWrite, the ALU result as the byte address, and RS2 data as the store data.
//  Models a multi-cycle word SRAM and raises stall_o so hazard logic freezes PC, IF/ID, ID/EX and EX/MEM until the access completes.
//  Load data goes to MEM/WB via rdata_o.
// PARAMETERS
//  DEPTH    1024  number of 32-bit words; power of two
//  LATENCY  2     stall cycles per access; legal range 1..15
// PORTS
//  clk_i        in   1   clock, rising edge
//  rst_i        in   1   reset, asynchronous, active-high
//  MemRead_i    in   1   load request from EX/MEM
//  MemWrite_i   in   1   store request from EX/MEM
//  addr_i       in   32  byte address (ALU result)
//  wdata_i      in   32  store data (RS2 data)
//  rdata_o      out  32  load data; valid in the DONE cycle and held until the next load completes
//  stall_o      out  1   freeze request to the pipeline
//  busy_o       out  1   FSM is not IDLE (debug/perf)
// BEHAVIOUR
//  - Reset (async, rst_i=1): state=IDLE, cnt=0, rdata_o=0, stall_o=0, busy_o=0, request regs=0.
//    Memory array contents are not cleared. Any write still in flight is dropped.
//  - States: IDLE, BUSY, DONE.
//  - Request: req = MemRead_i | MemWrite_i. Index = addr_i[log2(DEPTH)+1:2].
//    addr_i[1:0] is ignored; upper bits wrap modulo DEPTH.
//  - IDLE, req=1, cycle T: stall_o=1 combinationally.
//    At the edge: capture is_wr = MemWrite_i, index and wdata; cnt <= LATENCY-1; go to BUSY.
//  - IDLE, req=0: stall_o=0; stay in IDLE.
//  - BUSY: stall_o=1. Decrement cnt each cycle. At the edge where cnt==0, perform the access and go to DONE:
//    - write: mem[index] <= wdata
//    - read: rdata_o <= mem[index]
//  - DONE: stall_o=0, so the pipeline advances at the end of this cycle. Go to IDLE unconditionally.
//  - Timing: stall_o is high in cycles T..T+LATENCY-1 and low in T+LATENCY (DONE).
//    Total access = LATENCY+1 cycles. LATENCY=1 gives exactly one stall cycle.
//  - Back-to-back: a new request is presented in the cycle after DONE and is accepted from IDLE.
//    There is always one IDLE cycle between accesses.
//  - Inputs are sampled only at acceptance. Changes to any input during BUSY or DONE are ignored.
//  - MemRead_i and MemWrite_i both high: treated as a store. rdata_o is unchanged.
//  - A store never modifies rdata_o. A load never modifies the array.
//  - rst_i asserted in BUSY: the write is not committed; return to IDLE; stall_o=0.
//  - busy_o = (state != IDLE).
// STRUCTURE
//  - Shared package: state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2), word width 32, byte-offset width 2.
//  - One sub-module, dmem_array: single-port synchronous word RAM.
//    Ports: clk, we, re, index, wdata, rdata. No reset on storage.
//  - Top level holds the FSM, the latency counter, the request capture registers and the rdata_o register.
//  - stall_o is decoded combinationally from state and req.
// TESTING
//  1. LATENCY=2: store 0xDEADBEEF to addr 0x10, then load from 0x10.
//     -> stall_o high for 2 cycles on each access; rdata_o=0xDEADBEEF in the load's DONE cycle.
//  2. Back-to-back stores to 0x0, 0x4, 0x8 followed by loads of the same addresses.
//     -> each access is 3 cycles plus 1 IDLE; data read back matches.
//  3. MemRead_i=MemWrite_i=1, addr 0x20, wdata 0x5A5A5A5A.
//     -> mem[8]=0x5A5A5A5A; rdata_o keeps its prior value.
//  4. Store 0x12345678 to 0x40, with reset pulsed during BUSY; then load 0x40.
//     -> stall_o drops immediately on reset; the load returns the old contents, not 0x12345678.
//  5. DEPTH=1024: store 0xCAFEF00D to 0x1004, then load 0x0004 and 0x0007.
//     -> both loads return 0xCAFEF00D (wrap and offset ignore).
//  6. LATENCY=1: change addr_i and wdata_i in the cycle after acceptance.
//     -> exactly 1 stall cycle; the originally captured address and data are used.

Source files
------------

// File: rtl/mem_stage_dmem_pkg.sv
// Shared definitions for the MEM-stage data memory: FSM encoding and datapath widths.
package mem_stage_dmem_pkg;

   localparam int WORD_W = 32;
   localparam int OFFS_W = 2;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM; the read register only updates on a read, so it holds the last loaded word.
module dmem_array
   import mem_stage_dmem_pkg::*;
#(
   parameter int DEPTH = 1024,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic              re,
   input  logic [IDX_W-1:0]  index,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[index] <= wdata;
      end else if (re) begin
         rdata <= mem[index];
      end
   end

endmodule

// File: rtl/mem_stage_dmem.sv
// MEM-stage data memory responder: multi-cycle word SRAM access with a pipeline stall request.
// FSM IDLE -> BUSY -> DONE -> IDLE; stall is held from the request cycle until the DONE cycle.
module mem_stage_dmem
   import mem_stage_dmem_pkg::*;
#(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              MemRead_i,
   input  logic              MemWrite_i,
   input  logic [WORD_W-1:0] addr_i,
   input  logic [WORD_W-1:0] wdata_i,
   output logic [WORD_W-1:0] rdata_o,
   output logic              stall_o,
   output logic              busy_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam bit SINGLE_CYCLE = (LATENCY == 1);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                is_wr_q, is_wr_d;
   logic [IDX_W-1:0]    index_q, index_d;
   logic [WORD_W-1:0]   wdata_q, wdata_d;
   logic                rd_valid_q, rd_valid_d;

   logic                req;
   logic [IDX_W-1:0]    in_index;
   logic                fire;
   logic                acc_wr;
   logic [IDX_W-1:0]    acc_index;
   logic [WORD_W-1:0]   acc_wdata;
   logic                ram_we;
   logic                ram_re;
   logic [WORD_W-1:0]   ram_rdata;
   logic                unused_addr;

   assign req         = MemRead_i | MemWrite_i;
   assign in_index    = addr_i[IDX_W+OFFS_W-1:OFFS_W];
   assign unused_addr = ^{addr_i[WORD_W-1:IDX_W+OFFS_W], addr_i[OFFS_W-1:0]};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         is_wr_q    <= 1'b0;
         index_q    <= '0;
         wdata_q    <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_wr_q    <= is_wr_d;
         index_q    <= index_d;
         wdata_q    <= wdata_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   // cnt holds the stall cycles still to come; the access fires on the edge that ends the last one.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      is_wr_d = is_wr_q;
      index_d = index_q;
      wdata_d = wdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (req) begin
               is_wr_d = MemWrite_i;
               index_d = in_index;
               wdata_d = wdata_i;
               cnt_d   = CNT_W'(LATENCY - 1);
               state_d = SINGLE_CYCLE ? ST_DONE : ST_BUSY;
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // With LATENCY=1 the access happens on the acceptance edge, so it uses the live inputs.
   always_comb begin
      fire      = ((state_q == ST_IDLE) && req && SINGLE_CYCLE) ||
                  ((state_q == ST_BUSY) && (cnt_q == CNT_W'(1)));
      acc_wr    = (state_q == ST_IDLE) ? MemWrite_i : is_wr_q;
      acc_index = (state_q == ST_IDLE) ? in_index   : index_q;
      acc_wdata = (state_q == ST_IDLE) ? wdata_i    : wdata_q;
      ram_we    = fire &  acc_wr & ~rst_i;
      ram_re    = fire & ~acc_wr & ~rst_i;
      rd_valid_d = rd_valid_q | ram_re;
   end

   always_comb begin
      stall_o = ~rst_i & (((state_q == ST_IDLE) && req) || (state_q == ST_BUSY));
      busy_o  = (state_q != ST_IDLE);
      rdata_o = rd_valid_q ? ram_rdata : '0;
   end

   dmem_array #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_array (
      .clk   (clk_i),
      .we    (ram_we),
      .re    (ram_re),
      .index (acc_index),
      .wdata (acc_wdata),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_mem_stage_dmem.sv
// Scoreboard bench: stimulus pushes expected DONE-cycle results, per-DUT monitors pop and compare.
// DUT 1 runs with LATENCY=2, DUT 2 with LATENCY=1.
module tb_mem_stage_dmem;

   logic        clk = 1'b0;
   logic        rst;
   logic        rd1, wr1, rd2, wr2;
   logic [31:0] addr1, wdata1, addr2, wdata2;
   logic [31:0] rdata1, rdata2;
   logic        stall1, busy1, stall2, busy2;

   int checks = 0;
   int passes = 0;
   int stall_cnt1 = 0;
   int stall_cnt2 = 0;

   logic [31:0] exp_data1[$];
   string       exp_name1[$];
   logic [31:0] exp_data2[$];
   string       exp_name2[$];

   always #5 clk = ~clk;

   mem_stage_dmem #(.DEPTH(1024), .LATENCY(2)) dut1 (
      .clk_i(clk), .rst_i(rst), .MemRead_i(rd1), .MemWrite_i(wr1),
      .addr_i(addr1), .wdata_i(wdata1), .rdata_o(rdata1),
      .stall_o(stall1), .busy_o(busy1)
   );

   mem_stage_dmem #(.DEPTH(1024), .LATENCY(1)) dut2 (
      .clk_i(clk), .rst_i(rst), .MemRead_i(rd2), .MemWrite_i(wr2),
      .addr_i(addr2), .wdata_i(wdata2), .rdata_o(rdata2),
      .stall_o(stall2), .busy_o(busy2)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
      checks++;
      if (actual === required) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, required);
      end
   endtask

   // Caller is in an IDLE cycle just after a rising edge; returns in the IDLE cycle after DONE.
   task automatic applyStimulus(input int which, input bit rd, input bit wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp_rdata, input string name);
      bit done = 1'b0;
      if (which == 1) begin
         exp_data1.push_back(exp_rdata);
         exp_name1.push_back(name);
         rd1 = rd; wr1 = wr; addr1 = addr; wdata1 = wdata;
      end else begin
         exp_data2.push_back(exp_rdata);
         exp_name2.push_back(name);
         rd2 = rd; wr2 = wr; addr2 = addr; wdata2 = wdata;
      end
      @(posedge clk);
      #2;
      if (which == 1) begin
         rd1 = 1'b0; wr1 = 1'b0; addr1 = addr ^ 32'h0000_0044; wdata1 = ~wdata;
      end else begin
         rd2 = 1'b0; wr2 = 1'b0; addr2 = addr ^ 32'h0000_0004; wdata2 = ~wdata;
      end
      for (int i = 0; i < 40; i++) begin
         if (!((which == 1) ? busy1 : busy2)) begin
            done = 1'b1;
            break;
         end
         @(posedge clk);
         #2;
      end
      if (!done) begin
         checks++;
         $display("[TB] FAIL %s timeout: busy still 1, required 0 within 40 cycles", name);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         stall_cnt1 = 0;
      end else begin
         if (stall1) stall_cnt1++;
         if (busy1 && !stall1) begin
            if (exp_data1.size() == 0) begin
               checks++;
               $display("[TB] FAIL dut1 unexpected DONE: got rdata 0x%08h, required no access", rdata1);
            end else begin
               checkOutput({exp_name1[0], " rdata"}, rdata1, exp_data1[0]);
               checkOutput({exp_name1[0], " stalls"}, 32'(stall_cnt1), 32'd2);
               void'(exp_data1.pop_front());
               void'(exp_name1.pop_front());
            end
            stall_cnt1 = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         stall_cnt2 = 0;
      end else begin
         if (stall2) stall_cnt2++;
         if (busy2 && !stall2) begin
            if (exp_data2.size() == 0) begin
               checks++;
               $display("[TB] FAIL dut2 unexpected DONE: got rdata 0x%08h, required no access", rdata2);
            end else begin
               checkOutput({exp_name2[0], " rdata"}, rdata2, exp_data2[0]);
               checkOutput({exp_name2[0], " stalls"}, 32'(stall_cnt2), 32'd1);
               void'(exp_data2.pop_front());
               void'(exp_name2.pop_front());
            end
            stall_cnt2 = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at 200000, required $finish earlier");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst = 1'b1;
      rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
      rd2 = 1'b0; wr2 = 1'b0; addr2 = '0; wdata2 = '0;
      repeat (2) @(posedge clk);
      #2;
      checkOutput("reset dut1 rdata", rdata1, 32'h0);
      checkOutput("reset dut1 stall", {31'b0, stall1}, 32'h0);
      checkOutput("reset dut1 busy",  {31'b0, busy1},  32'h0);
      checkOutput("reset dut2 rdata", rdata2, 32'h0);
      checkOutput("reset dut2 busy",  {31'b0, busy2},  32'h0);
      rst = 1'b0;
      @(posedge clk);
      #2;

      applyStimulus(1, 0, 1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, "st 0x10");
      applyStimulus(1, 1, 0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, "ld 0x10");

      applyStimulus(1, 0, 1, 32'h0000_0000, 32'h1111_0000, 32'hDEAD_BEEF, "st 0x0");
      applyStimulus(1, 0, 1, 32'h0000_0004, 32'h2222_0004, 32'hDEAD_BEEF, "st 0x4");
      applyStimulus(1, 0, 1, 32'h0000_0008, 32'h3333_0008, 32'hDEAD_BEEF, "st 0x8");
      applyStimulus(1, 1, 0, 32'h0000_0000, 32'h0,         32'h1111_0000, "ld 0x0");
      applyStimulus(1, 1, 0, 32'h0000_0004, 32'h0,         32'h2222_0004, "ld 0x4");
      applyStimulus(1, 1, 0, 32'h0000_0008, 32'h0,         32'h3333_0008, "ld 0x8");

      applyStimulus(1, 1, 1, 32'h0000_0020, 32'h5A5A_5A5A, 32'h3333_0008, "rdwr 0x20");
      applyStimulus(1, 1, 0, 32'h0000_0020, 32'h0,         32'h5A5A_5A5A, "ld 0x20");

      applyStimulus(1, 0, 1, 32'h0000_0040, 32'h1111_1111, 32'h5A5A_5A5A, "st 0x40 old");
      rd1 = 1'b0; wr1 = 1'b1; addr1 = 32'h0000_0040; wdata1 = 32'h1234_5678;
      @(posedge clk);
      #2;
      rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;
      checkOutput("abort in busy", {31'b0, busy1}, 32'h1);
      rst = 1'b1;
      #1;
      checkOutput("abort stall", {31'b0, stall1}, 32'h0);
      checkOutput("abort busy",  {31'b0, busy1},  32'h0);
      checkOutput("abort rdata", rdata1, 32'h0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #2;
      applyStimulus(1, 1, 0, 32'h0000_0040, 32'h0,         32'h1111_1111, "ld 0x40 after abort");

      applyStimulus(1, 0, 1, 32'h0000_1004, 32'hCAFE_F00D, 32'h1111_1111, "st 0x1004");
      applyStimulus(1, 1, 0, 32'h0000_0004, 32'h0,         32'hCAFE_F00D, "ld 0x4 wrap");
      applyStimulus(1, 1, 0, 32'h0000_0007, 32'h0,         32'hCAFE_F00D, "ld 0x7 offset");

      applyStimulus(2, 0, 1, 32'h0000_0104, 32'h0BAD_BEEF, 32'h0000_0000, "l1 st 0x104");
      applyStimulus(2, 0, 1, 32'h0000_0100, 32'hA5A5_0001, 32'h0000_0000, "l1 st 0x100");
      applyStimulus(2, 1, 0, 32'h0000_0104, 32'h0,         32'h0BAD_BEEF, "l1 ld 0x104");
      applyStimulus(2, 1, 0, 32'h0000_0100, 32'h0,         32'hA5A5_0001, "l1 ld 0x100");

      repeat (3) @(posedge clk);
      #2;
      checkOutput("dut1 queue drained", 32'(exp_data1.size()), 32'h0);
      checkOutput("dut2 queue drained", 32'(exp_data2.size()), 32'h0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
